// File: rtl/mac_nbit_pipe.sv
// Parametrised four-stage multiply-accumulate unit with valid-qualified input, auto-dump
// after a programmable sample count, sticky overflow per result and a saturating output window.
module mac_nbit_pipe #(
  parameter int unsigned MULTI_WIDTH = 8,
  parameter int unsigned PAD_ZERO    = 2,
  parameter int unsigned ACC_WIDTH   = 2*(MULTI_WIDTH+PAD_ZERO),
  parameter int unsigned OUT_WIDTH   = MULTI_WIDTH,
  parameter int unsigned SEL_WIDTH   = 6,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                   MAC_ACC_CLK,
  input  logic                   acc_ff_rst,
  input  logic                   EFPGA_MATHB_CLK_EN,
  input  logic                   MAC_IN_VALID,
  input  logic [MULTI_WIDTH-1:0] MAC_OPER_DATA,
  input  logic [MULTI_WIDTH-1:0] MAC_COEF_DATA,
  input  logic                   MAC_TC,
  input  logic                   MAC_ACC_CLEAR,
  input  logic                   MAC_ACC_RND,
  input  logic                   MAC_ACC_SAT,
  input  logic [SEL_WIDTH-1:0]   MAC_OUT_SEL,
  input  logic [CNT_WIDTH-1:0]   MAC_ACC_LEN,
  output logic [OUT_WIDTH-1:0]   MAC_OUT,
  output logic                   MAC_OUT_VALID,
  output logic                   MAC_OVF,
  output logic [CNT_WIDTH-1:0]   MAC_ACC_CNT
);

  localparam int unsigned PW = 2*MULTI_WIDTH + 2;
  localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(ACC_WIDTH - OUT_WIDTH);

  logic en;
  assign en = EFPGA_MATHB_CLK_EN;

  // S1: operand and control capture
  logic                   s1_valid, s1_tc, s1_clear, s1_rnd, s1_sat;
  logic [MULTI_WIDTH-1:0] s1_oper, s1_coef;
  logic [SEL_WIDTH-1:0]   s1_sel;
  logic [CNT_WIDTH-1:0]   s1_len;

  always_ff @(posedge MAC_ACC_CLK) begin
    if (acc_ff_rst) begin
      s1_valid <= 1'b0;
      s1_tc    <= 1'b0;
      s1_clear <= 1'b0;
      s1_rnd   <= 1'b0;
      s1_sat   <= 1'b0;
      s1_oper  <= '0;
      s1_coef  <= '0;
      s1_sel   <= '0;
      s1_len   <= '0;
    end else if (en) begin
      s1_valid <= MAC_IN_VALID;
      s1_tc    <= MAC_TC;
      s1_clear <= MAC_ACC_CLEAR;
      s1_rnd   <= MAC_ACC_RND;
      s1_sat   <= MAC_ACC_SAT;
      s1_oper  <= MAC_OPER_DATA;
      s1_coef  <= MAC_COEF_DATA;
      s1_sel   <= MAC_OUT_SEL;
      s1_len   <= MAC_ACC_LEN;
    end
  end

  // S2: full-precision product; one guard bit lets unsigned operands share the signed multiplier
  logic signed [PW-1:0] a_ext, b_ext, prod_full;
  always_comb begin
    a_ext     = PW'($signed({s1_tc & s1_oper[MULTI_WIDTH-1], s1_oper}));
    b_ext     = PW'($signed({s1_tc & s1_coef[MULTI_WIDTH-1], s1_coef}));
    prod_full = a_ext * b_ext;
  end

  logic                 s2_valid, s2_tc, s2_clear, s2_rnd, s2_sat;
  logic [ACC_WIDTH-1:0] s2_prod;
  logic [SEL_WIDTH-1:0] s2_sel;
  logic [CNT_WIDTH-1:0] s2_len;

  always_ff @(posedge MAC_ACC_CLK) begin
    if (acc_ff_rst) begin
      s2_valid <= 1'b0;
      s2_tc    <= 1'b0;
      s2_clear <= 1'b0;
      s2_rnd   <= 1'b0;
      s2_sat   <= 1'b0;
      s2_prod  <= '0;
      s2_sel   <= '0;
      s2_len   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_tc    <= s1_tc;
      s2_clear <= s1_clear;
      s2_rnd   <= s1_rnd;
      s2_sat   <= s1_sat;
      s2_prod  <= ACC_WIDTH'(prod_full);
      s2_sel   <= s1_sel;
      s2_len   <= s1_len;
    end
  end

  // S3: accumulator, sample counter, sticky overflow and dump decision
  logic [ACC_WIDTH-1:0] acc, seed, base, sum;
  logic [ACC_WIDTH:0]   sum_ext;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 ovf, ovf_next, add_ovf, start, dump, start_pend;
  logic                 s3_dump, s3_tc, s3_sat;
  logic [SEL_WIDTH-1:0] s3_sel;

  always_comb begin
    start = s2_clear | start_pend;
    seed  = '0;
    if (s2_rnd && (s2_sel != '0)) seed = ACC_WIDTH'(1) << (s2_sel - SEL_WIDTH'(1));
    base    = start ? seed : acc;
    sum_ext = {1'b0, base} + {1'b0, s2_prod};
    sum     = sum_ext[ACC_WIDTH-1:0];
    add_ovf = s2_tc ? ((base[ACC_WIDTH-1] == s2_prod[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]))
                    : sum_ext[ACC_WIDTH];
    cnt_next = start ? CNT_WIDTH'(1) : ((cnt == '1) ? cnt : cnt + CNT_WIDTH'(1));
    ovf_next = add_ovf | (~start & ovf);
    dump     = (s2_len == '0) || (cnt_next == s2_len);
  end

  always_ff @(posedge MAC_ACC_CLK) begin
    if (acc_ff_rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      start_pend <= 1'b0;
      s3_dump    <= 1'b0;
      s3_tc      <= 1'b0;
      s3_sat     <= 1'b0;
      s3_sel     <= '0;
    end else if (en) begin
      s3_dump <= s2_valid & dump;
      if (s2_valid) begin
        acc        <= sum;
        cnt        <= cnt_next;
        ovf        <= ovf_next;
        start_pend <= (s2_len != '0) && dump;
        s3_tc      <= s2_tc;
        s3_sat     <= s2_sat;
        s3_sel     <= s2_sel;
      end
    end
  end

  // S4: window select and saturation
  logic [SEL_WIDTH-1:0] s_amt;
  logic [ACC_WIDTH-1:0] shr;
  logic                 in_range;
  logic [OUT_WIDTH-1:0] res;

  always_comb begin
    s_amt = (s3_sel > SEL_MAX) ? SEL_MAX : s3_sel;
    if (s3_tc) shr = $signed(acc) >>> s_amt;
    else       shr = acc >> s_amt;
    in_range = s3_tc ? ((&shr[ACC_WIDTH-1:OUT_WIDTH-1]) || ~(|shr[ACC_WIDTH-1:OUT_WIDTH-1]))
                     : ~(|shr[ACC_WIDTH-1:OUT_WIDTH]);
    if (!s3_sat || in_range) res = shr[OUT_WIDTH-1:0];
    else if (!s3_tc)         res = '1;
    else if (acc[ACC_WIDTH-1]) res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                     res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  logic [OUT_WIDTH-1:0] out_r;
  logic                 ovf_r, valid_r;

  always_ff @(posedge MAC_ACC_CLK) begin
    if (acc_ff_rst) begin
      out_r   <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (en) begin
      valid_r <= s3_dump;
      if (s3_dump) begin
        out_r <= res;
        ovf_r <= ovf;
      end
    end
  end

  // A held S4 result is only shown while enabled, so it is consumed by exactly one enabled edge
  assign MAC_OUT       = out_r;
  assign MAC_OVF       = ovf_r;
  assign MAC_OUT_VALID = valid_r & en;
  assign MAC_ACC_CNT   = cnt;

endmodule

// File: tb/tb_mac_nbit_pipe.sv
// Self-checking bench for mac_nbit_pipe: arithmetic reference model with per-cycle compare,
// directed scenarios with literal expectations, and a randomized run.
module tb_mac_nbit_pipe;
  localparam int MW = 8;
  localparam int AW = 20;
  localparam int OW = 8;
  localparam int SW = 6;
  localparam int CW = 8;
  localparam longint AMOD = longint'(1) << AW;

  logic clk = 1'b0;
  logic rst, en, vin, tc, clr, rnd, sat;
  logic [MW-1:0] oper, coef;
  logic [SW-1:0] sel;
  logic [CW-1:0] len;
  logic [OW-1:0] mac_out;
  logic          out_valid, ovf_o;
  logic [CW-1:0] acc_cnt;

  always #5 clk = ~clk;

  mac_nbit_pipe dut (
    .MAC_ACC_CLK(clk), .acc_ff_rst(rst), .EFPGA_MATHB_CLK_EN(en), .MAC_IN_VALID(vin),
    .MAC_OPER_DATA(oper), .MAC_COEF_DATA(coef), .MAC_TC(tc), .MAC_ACC_CLEAR(clr),
    .MAC_ACC_RND(rnd), .MAC_ACC_SAT(sat), .MAC_OUT_SEL(sel), .MAC_ACC_LEN(len),
    .MAC_OUT(mac_out), .MAC_OUT_VALID(out_valid), .MAC_OVF(ovf_o), .MAC_ACC_CNT(acc_cnt)
  );

  typedef struct { longint due; logic [7:0] out; logic ovf; } exp_t;
  typedef struct { logic [7:0] out; logic ovf; } obs_t;
  exp_t q[$];
  obs_t log_q[$];

  int checks = 0, errors = 0, stall_viol = 0;
  longint en_cnt = 0;
  longint m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 0, m_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic longint s20(longint x);
    return (x >= AMOD/2) ? x - AMOD : x;
  endfunction

  // Reference: plain integer arithmetic on the accepted sample stream
  function automatic void model_step();
    longint a, b, p, seed, base, sum, w, v;
    bit start, ov, dump, in_r;
    int s;
    logic [7:0] o;
    a = tc ? longint'($signed(oper)) : longint'(oper);
    b = tc ? longint'($signed(coef)) : longint'(coef);
    p = (a * b) & (AMOD - 1);
    start = clr || m_pend;
    seed = (rnd && sel != 0 && int'(sel) <= AW) ? (longint'(1) << (int'(sel) - 1)) : 0;
    base = start ? seed : m_acc;
    if (tc) begin
      sum = s20(base) + s20(p);
      ov = (sum > AMOD/2 - 1) || (sum < -(AMOD/2));
    end else begin
      sum = base + p;
      ov = sum >= AMOD;
    end
    m_acc = sum & (AMOD - 1);
    if (start) m_cnt = 1;
    else if (m_cnt < 255) m_cnt++;
    m_ovf = start ? ov : (m_ovf | ov);
    dump = (len == 0) || (m_cnt == int'(len));
    m_pend = (len != 0) && dump;
    if (dump) begin
      s = (int'(sel) > AW - OW) ? AW - OW : int'(sel);
      if (tc) begin
        v = s20(m_acc);
        w = v >>> s;
        in_r = (w >= -128) && (w <= 127);
        o = (in_r || !sat) ? w[7:0] : ((v < 0) ? 8'h80 : 8'h7F);
      end else begin
        w = m_acc >> s;
        o = (w <= 255 || !sat) ? w[7:0] : 8'hFF;
      end
      q.push_back('{en_cnt + 3, o, m_ovf});
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_pend = 0;
    end else if (en) begin
      en_cnt++;
      if (vin) model_step();
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (q.size() > 0 && q[0].due < en_cnt) begin
      chk("missed_result", 0, 1);
      void'(q.pop_front());
    end
    ev = (q.size() > 0) && (q[0].due == en_cnt) && en;
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      chk("mac_out", 64'(mac_out), 64'(q[0].out));
      chk("mac_ovf", 64'(ovf_o), 64'(q[0].ovf));
      void'(q.pop_front());
    end
    if (out_valid === 1'b1) log_q.push_back('{mac_out, ovf_o});
    if (!en && out_valid !== 1'b0) stall_viol++;
  end

  function automatic logic [7:0] log_out(int i);
    if (i < log_q.size()) return log_q[i].out;
    return 8'hxx;
  endfunction

  function automatic logic log_ovf(int i);
    if (i < log_q.size()) return log_q[i].ovf;
    return 1'bx;
  endfunction

  task automatic send(input int a, input int b, input bit t, input bit c, input bit r,
                      input bit s, input int sl, input int ln);
    oper = MW'(a); coef = MW'(b); tc = t; clr = c; rnd = r; sat = s;
    sel = SW'(sl); len = CW'(ln); vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0; clr = 1'b0;
  endtask

  task automatic drain();
    vin = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 20);
    chk(name, 64'(out_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int exp4[6];
    int cur_len;
    int lens[6];
    exp4 = '{1, 5, 14, 30, 55, 91};
    lens = '{0, 1, 2, 3, 4, 7};
    rst = 1; en = 1; vin = 0; tc = 0; clr = 0; rnd = 0; sat = 0;
    oper = '0; coef = '0; sel = '0; len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out", 64'(mac_out), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ovf", 64'(ovf_o), 0);
    chk("rst_cnt", 64'(acc_cnt), 0);

    // Unsigned dot product
    send(3, 5, 0, 1, 0, 0, 0, 4);
    send(2, 7, 0, 0, 0, 0, 0, 4);
    send(10, 1, 0, 0, 0, 0, 0, 4);
    send(1, 1, 0, 0, 0, 0, 0, 4);
    wait_strobe("dot_strobe", n);
    chk("dot_latency", 64'(n), 4);
    chk("dot_out", 64'(mac_out), 64'h28);
    chk("dot_ovf", 64'(ovf_o), 0);
    chk("dot_cnt", 64'(acc_cnt), 4);
    drain();

    // Signed saturation
    log_q.delete();
    send(-128, -128, 1, 1, 0, 1, 0, 2);
    send(-128, -128, 1, 0, 0, 1, 0, 2);
    send(-128, 127, 1, 1, 0, 1, 0, 2);
    send(-128, 127, 1, 0, 0, 1, 0, 2);
    send(-128, -128, 1, 1, 0, 0, 0, 2);
    send(-128, -128, 1, 0, 0, 0, 0, 2);
    drain();
    chk("sat_count", 64'(log_q.size()), 3);
    chk("sat_pos", 64'(log_out(0)), 64'h7F);
    chk("sat_neg", 64'(log_out(1)), 64'h80);
    chk("sat_off", 64'(log_out(2)), 64'h00);

    // Rounding and select clamp
    log_q.delete();
    send(24, 1, 0, 1, 1, 0, 4, 1);
    send(24, 1, 0, 0, 0, 0, 4, 1);
    send(255, 255, 0, 0, 1, 0, 63, 1);
    send(255, 255, 0, 0, 0, 1, 0, 1);
    drain();
    chk("rnd_count", 64'(log_q.size()), 4);
    chk("rnd_on", 64'(log_out(0)), 64'h02);
    chk("rnd_off", 64'(log_out(1)), 64'h01);
    chk("sel_clamp", 64'(log_out(2)), 64'h0F);
    chk("usat", 64'(log_out(3)), 64'hFF);

    // Stall in the middle of a free-running stream
    log_q.delete();
    stall_viol = 0;
    for (int i = 1; i <= 3; i++) send(i, i, 0, i == 1, 0, 0, 0, 0);
    en = 0;
    repeat (5) @(posedge clk);
    #1 en = 1;
    for (int i = 4; i <= 6; i++) send(i, i, 0, 0, 0, 0, 0, 0);
    drain();
    chk("stall_count", 64'(log_q.size()), 6);
    for (int i = 0; i < 6; i++) chk("stall_val", 64'(log_out(i)), 64'(exp4[i]));
    chk("stall_valid_low", 64'(stall_viol), 0);

    // Unsigned wrap sets overflow only on the wrapping result
    log_q.delete();
    for (int i = 0; i < 17; i++) send(255, 255, 0, i == 0, 0, 0, 0, 0);
    send(255, 255, 0, 1, 0, 0, 0, 0);
    drain();
    chk("ovf_count", 64'(log_q.size()), 18);
    for (int i = 0; i < 16; i++) chk("ovf_early", 64'(log_ovf(i)), 0);
    chk("ovf_val16", 64'(log_out(15)), 64'h10);
    chk("ovf_set", 64'(log_ovf(16)), 1);
    chk("ovf_wrap_val", 64'(log_out(16)), 64'h11);
    chk("ovf_clear", 64'(log_ovf(17)), 0);
    chk("ovf_clear_val", 64'(log_out(17)), 64'h01);

    // Reset mid-accumulation
    log_q.delete();
    send(5, 5, 0, 1, 0, 0, 0, 4);
    send(6, 6, 0, 0, 0, 0, 0, 4);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_out", 64'(mac_out), 0);
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_ovf", 64'(ovf_o), 0);
    chk("mid_rst_cnt", 64'(acc_cnt), 0);
    send(1, 2, 0, 1, 0, 0, 0, 4);
    send(3, 4, 0, 0, 0, 0, 0, 4);
    send(5, 6, 0, 0, 0, 0, 0, 4);
    send(7, 8, 0, 0, 0, 0, 0, 4);
    drain();
    chk("post_rst_count", 64'(log_q.size()), 1);
    chk("post_rst_sum", 64'(log_out(0)), 64'h64);

    // Randomized stream against the model
    cur_len = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        cur_len = lens[$urandom_range(0, 5)];
        tc = 1'($urandom_range(0, 1));
      end
      en   = ($urandom_range(0, 7) != 0);
      vin  = ($urandom_range(0, 3) != 0);
      oper = MW'($urandom);
      coef = MW'($urandom);
      clr  = ($urandom_range(0, 9) == 0);
      rnd  = 1'($urandom_range(0, 1));
      sat  = 1'($urandom_range(0, 1));
      sel  = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(13, 63)) : SW'($urandom_range(0, 12));
      len  = CW'(cur_len);
      @(posedge clk);
      #1;
    end
    vin = 0; en = 1; clr = 0;
    drain();
    chk("rand_queue_empty", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
